// File: rtl/nfc_dq_read_capture.sv
// NAND read capture: DQS edge detection on 4 samples/clock, byte counting, 16-bit word packing.
// Edge in cycle N is buffered end of N+1 and can be on oData in N+2; the NAND cannot stall, so a full buffer drops bytes and sets oOverflow.
module nfc_dq_read_capture #(
   parameter int NumberOfSamples  = 4,
   parameter int BufferDepthBytes = 8,
   parameter int TimeoutCycles    = 64
) (
   input  logic                         iSystemClock,
   input  logic                         iModuleReset,
   input  logic                         iCaptureStart,
   input  logic [15:0]                  iCaptureLength,
   input  logic [NumberOfSamples-1:0]   iPI_DQStrobe,
   input  logic [8*NumberOfSamples-1:0] iPI_DQ,
   output logic [15:0]                  oData,
   output logic                         oDataValid,
   input  logic                         iDataReady,
   output logic                         oCaptureBusy,
   output logic                         oCaptureDone,
   output logic                         oTimeout,
   output logic                         oOverflow
);
   localparam int NS = NumberOfSamples;
   localparam int PW = $clog2(BufferDepthBytes);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TimeoutCycles + 1);

   typedef enum logic [2:0] {IDLE, PREAMBLE, CAPTURE, DRAIN, DONE} state_t;
   state_t state_q, state_d;

   logic [NS-1:0]   dqs_q;
   logic [8*NS-1:0] dq_q;
   logic            prev_dqs;
   logic [NS:0]     dqs_ext;
   logic [NS-1:0]   edge_v, rise_v;
   logic [15:0]     byte_cnt, remain;
   logic [TW-1:0]   timer;
   logic [7:0]      mem [BufferDepthBytes];
   logic [PW-1:0]   wr_ptr, rd_ptr, rd_nxt;
   logic [CW-1:0]   fifo_cnt, n_wr;
   logic [1:0]      n_rd;
   logic [NS-1:0]   wr_en;
   logic [PW-1:0]   wr_slot [NS];
   logic            armed, got_rise, drop, timeout_hit, word_full, accept;

   always_ff @(posedge iSystemClock or negedge iModuleReset) begin
      if (!iModuleReset) begin
         dqs_q    <= '0;
         dq_q     <= '0;
         prev_dqs <= 1'b0;
      end else begin
         dqs_q    <= iPI_DQStrobe;
         dq_q     <= iPI_DQ;
         prev_dqs <= dqs_q[NS-1];
      end
   end

   // Last sample of the previous cycle acts as sample -1, so boundary edges land on sample 0.
   assign dqs_ext = {dqs_q, prev_dqs};
   assign edge_v  = dqs_q ^ dqs_ext[NS-1:0];
   assign rise_v  = dqs_q & ~dqs_ext[NS-1:0];

   always_comb begin
      armed    = (state_q == CAPTURE);
      got_rise = 1'b0;
      remain   = byte_cnt;
      n_wr     = '0;
      drop     = 1'b0;
      for (int k = 0; k < NS; k++) begin
         wr_en[k]   = 1'b0;
         wr_slot[k] = wr_ptr + n_wr[PW-1:0];
         if ((state_q == PREAMBLE) && !armed && rise_v[k]) begin
            armed    = 1'b1;
            got_rise = 1'b1;
         end
         if (armed && edge_v[k] && (remain != 16'd0)) begin
            remain = remain - 16'd1;
            if (({1'b0, fifo_cnt} + {1'b0, n_wr}) < (CW+1)'(BufferDepthBytes)) begin
               wr_en[k] = 1'b1;
               n_wr     = n_wr + CW'(1);
            end else begin
               drop = 1'b1;
            end
         end
      end
   end

   assign timeout_hit = (state_q == PREAMBLE) && !got_rise && (timer == TW'(TimeoutCycles - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (iCaptureStart) state_d = (iCaptureLength == 16'd0) ? DONE : PREAMBLE;
         PREAMBLE: if (got_rise) state_d = CAPTURE;
                   else if (timeout_hit) state_d = IDLE;
         CAPTURE:  if (remain == 16'd0) state_d = DRAIN;
         DRAIN:    if (fifo_cnt == '0) state_d = DONE;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge iSystemClock or negedge iModuleReset) begin
      if (!iModuleReset) state_q <= IDLE;
      else               state_q <= state_d;
   end

   // Words are read straight from the buffer head; an odd leftover byte is released only once draining.
   assign rd_nxt     = rd_ptr + PW'(1);
   assign word_full  = (fifo_cnt >= CW'(2));
   assign oDataValid = word_full || ((fifo_cnt == CW'(1)) && (state_q == DRAIN));
   assign oData      = oDataValid ? {(word_full ? mem[rd_nxt] : 8'h00), mem[rd_ptr]} : 16'h0000;
   assign accept     = oDataValid && iDataReady;
   assign n_rd       = accept ? (word_full ? 2'd2 : 2'd1) : 2'd0;

   assign oCaptureBusy = (state_q == PREAMBLE) || (state_q == CAPTURE) || (state_q == DRAIN);
   assign oCaptureDone = (state_q == DONE);

   always_ff @(posedge iSystemClock) begin
      for (int k = 0; k < NS; k++)
         if (wr_en[k]) mem[wr_slot[k]] <= dq_q[8*k +: 8];
   end

   always_ff @(posedge iSystemClock or negedge iModuleReset) begin
      if (!iModuleReset) begin
         byte_cnt  <= '0;
         timer     <= '0;
         oTimeout  <= 1'b0;
         oOverflow <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fifo_cnt  <= '0;
      end else begin
         if ((state_q == IDLE) && iCaptureStart && (iCaptureLength != 16'd0)) begin
            byte_cnt  <= iCaptureLength;
            timer     <= '0;
            oTimeout  <= 1'b0;
            oOverflow <= 1'b0;
         end else begin
            byte_cnt <= remain;
            if (state_q == PREAMBLE) timer <= timer + TW'(1);
            if (timeout_hit) oTimeout <= 1'b1;
            if (drop) oOverflow <= 1'b1;
         end
         wr_ptr   <= wr_ptr + n_wr[PW-1:0];
         rd_ptr   <= rd_ptr + PW'(n_rd);
         fifo_cnt <= fifo_cnt + n_wr - CW'(n_rd);
      end
   end
endmodule

// File: tb/tb_nfc_dq_read_capture.sv
// Bench for nfc_dq_read_capture: table of capture scenarios plus hand sequences, scoreboard of expected words.
module tb_nfc_dq_read_capture;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] len = '0;
   logic [3:0]  dqs = '0;
   logic [31:0] dq = '0;
   logic        ready = 1'b0;
   logic [15:0] o_data;
   logic        o_vld, o_busy, o_done, o_to, o_ovf;

   int compared = 0, mismatched = 0, done_cnt = 0, words_seen = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_w;
   logic        lvl = 1'b0;

   typedef struct {
      int len; int nedges; int step; int pre; logic [7:0] base; int rdy_mode;
      int exp_words; logic exp_ovf;
   } vec_t;
   vec_t tbl[6];

   nfc_dq_read_capture dut (
      .iSystemClock(clk), .iModuleReset(rst_n), .iCaptureStart(start), .iCaptureLength(len),
      .iPI_DQStrobe(dqs), .iPI_DQ(dq), .oData(o_data), .oDataValid(o_vld), .iDataReady(ready),
      .oCaptureBusy(o_busy), .oCaptureDone(o_done), .oTimeout(o_to), .oOverflow(o_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (o_done) done_cnt++;
         if (o_vld && ready) begin
            words_seen++;
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL word_unexpected: got %h expected none", o_data);
            end else begin
               exp_w = exp_q.pop_front();
               check("word", {16'h0, o_data}, {16'h0, exp_w});
            end
         end
      end
   end

   // Model: DQS low for `pre` clocks, then toggles every `st` samples for `ne` edges; byte i = base + i*0x11.
   task automatic drive_capture(input int l, input int ne, input int st, input int pre,
                                input logic [7:0] base, input int keep, input int rmode);
      int ncyc;
      ncyc = pre + (ne * st + 3) / 4 + 1;
      for (int i = 0; i < keep; i += 2) begin
         logic [7:0] lo, hi;
         lo = base + 8'(i * 17);
         hi = (i + 1 < keep) ? base + 8'((i + 1) * 17) : 8'h00;
         exp_q.push_back({hi, lo});
      end
      lvl = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         start = (c == 0);
         len   = 16'(l);
         for (int k = 0; k < 4; k++) begin
            int t;
            t = (c - pre) * 4 + k;
            if (c >= pre && (t % st) == 0 && (t / st) < ne) begin
               lvl = ~lvl;
               dq[8*k +: 8] = base + 8'((t / st) * 17);
            end else begin
               dq[8*k +: 8] = 8'hEE;
            end
            dqs[k] = lvl;
         end
         ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
         tick();
         start = 1'b0;
         if (c == 0) check("busy_rise", {31'h0, o_busy}, 32'h1);
      end
   endtask

   task automatic wait_done(input int d0, input bit rnd);
      for (int i = 0; i < 400 && done_cnt == d0; i++) begin
         ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         tick();
      end
      ready = 1'b1;
      repeat (3) tick();
      check("done_pulse_count", done_cnt - d0, 1);
   endtask

   task automatic run_row(input vec_t v, input int idx);
      int d0, w0, keep;
      d0 = done_cnt;
      w0 = words_seen;
      keep = (v.len < v.nedges) ? v.len : v.nedges;
      drive_capture(v.len, v.nedges, v.step, v.pre, v.base, keep, v.rdy_mode);
      wait_done(d0, v.rdy_mode == 1);
      check($sformatf("row%0d_words", idx), words_seen - w0, v.exp_words);
      check($sformatf("row%0d_queue_empty", idx), exp_q.size(), 0);
      check($sformatf("row%0d_overflow", idx), {31'h0, o_ovf}, {31'h0, v.exp_ovf});
      check($sformatf("row%0d_timeout", idx), {31'h0, o_to}, 32'h0);
      check($sformatf("row%0d_busy_end", idx), {31'h0, o_busy}, 32'h0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int d0, w0;
      tbl[0] = '{4, 4, 2, 3, 8'hA1, 0, 2, 1'b0};
      tbl[1] = '{3, 4, 2, 3, 8'hA1, 0, 2, 1'b0};
      tbl[2] = '{5, 8, 4, 1, 8'h10, 1, 3, 1'b0};
      tbl[3] = '{7, 7, 1, 2, 8'h20, 1, 4, 1'b0};
      tbl[4] = '{6, 9, 3, 2, 8'h30, 1, 3, 1'b0};
      tbl[5] = '{1, 3, 2, 1, 8'h55, 0, 1, 1'b0};

      #12;
      check("reset_data", {16'h0, o_data}, 32'h0);
      check("reset_valid", {31'h0, o_vld}, 32'h0);
      check("reset_busy", {31'h0, o_busy}, 32'h0);
      check("reset_done", {31'h0, o_done}, 32'h0);
      check("reset_timeout", {31'h0, o_to}, 32'h0);
      check("reset_overflow", {31'h0, o_ovf}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      ready = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) run_row(tbl[i], i);

      // Zero length completes immediately without ever going busy
      start = 1'b1;
      len = 16'd0;
      tick();
      start = 1'b0;
      check("len0_done", {31'h0, o_done}, 32'h1);
      check("len0_busy", {31'h0, o_busy}, 32'h0);
      tick();
      check("len0_done_once", {31'h0, o_done}, 32'h0);

      // Timeout: DQS never rises
      d0 = done_cnt;
      dqs = 4'h0;
      dq = 32'hEEEE_EEEE;
      start = 1'b1;
      len = 16'd4;
      tick();
      start = 1'b0;
      for (int i = 1; i < 64; i++) tick();
      check("timeout_not_early", {31'h0, o_to}, 32'h0);
      check("timeout_busy_before", {31'h0, o_busy}, 32'h1);
      tick();
      check("timeout_set", {31'h0, o_to}, 32'h1);
      check("timeout_busy_drop", {31'h0, o_busy}, 32'h0);
      check("timeout_no_data", {31'h0, o_vld}, 32'h0);
      repeat (3) tick();
      check("timeout_no_done", done_cnt - d0, 0);

      run_row(tbl[0], 6);

      // Overflow with consumer stalled, plus an ignored start while busy
      d0 = done_cnt;
      w0 = words_seen;
      drive_capture(16, 16, 1, 1, 8'hA1, 8, 2);
      repeat (2) tick();
      check("ovf_flag", {31'h0, o_ovf}, 32'h1);
      check("ovf_busy_held", {31'h0, o_busy}, 32'h1);
      check("ovf_head_word", {16'h0, o_data}, 32'h0000_B2A1);
      start = 1'b1;
      len = 16'd2;
      tick();
      start = 1'b0;
      check("start_while_busy", {31'h0, o_busy}, 32'h1);
      wait_done(d0, 1'b0);
      check("ovf_words", words_seen - w0, 4);
      check("ovf_queue_empty", exp_q.size(), 0);

      run_row(tbl[3], 7);

      // Asynchronous reset during a capture with a word pending
      drive_capture(8, 8, 2, 2, 8'h40, 8, 2);
      check("prereset_valid", {31'h0, o_vld}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {10'h0, o_data, o_vld, o_busy, o_done, o_to, o_ovf}, 32'h0);
      exp_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      ready = 1'b1;
      tick();
      run_row(tbl[0], 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
